q5_my_serial_left_shifter: RTL and testbench

Sequential left shifter that is the dual of the combinational one-hot right barrel vector (W = D >> k). It accepts a data word and a one-hot shift amount through a start/ready handshake and shifts left one position per clock, zero-filling, until the selected amount is reached. It then presents D << k with a one-cycle done pulse. It sits beside the right-shift vector so benches can check round trips: right(left(D, k), k) equals D with the upper k bits cleared.

---
 rtl/q5_my_serial_left_shifter_if.sv | 23 ++
 rtl/q5_my_serial_left_shifter.sv | 87 ++++++++
 tb/tb_q5_my_serial_left_shifter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/q5_my_serial_left_shifter_if.sv
// Request/result bundle for the serial left shifter: start/din/amt in, status and result out.
interface q5_my_serial_left_shifter_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] amt;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             err;

  modport master (
    output start, din, amt,
    input  ready, busy, done, dout, err
  );

  modport slave (
    input  start, din, amt,
    output ready, busy, done, dout, err
  );
endinterface

// File: rtl/q5_my_serial_left_shifter.sv
// Serial left shifter: accepts din and a one-hot amount, shifts one bit per clock,
// then presents din << k with a one-cycle done pulse (err if amt was not one-hot).
module q5_my_serial_left_shifter #(
  parameter int WIDTH = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  q5_my_serial_left_shifter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout_q;
  logic             err_q;
  logic [CW-1:0]    idx;
  logic             one_hot;

  // Zero and multi-bit amounts are both rejected.
  assign one_hot = (bus.amt != '0) && ((bus.amt & (bus.amt - WIDTH'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.amt[i]) idx = CW'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = one_hot ? SHIFT : DONE;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh     <= '0;
      cnt    <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (one_hot) begin
              sh  <= bus.din;
              cnt <= idx;
            end else begin
              dout_q <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            dout_q <= sh;
            err_q  <= 1'b0;
          end else begin
            sh  <= {sh[WIDTH-2:0], 1'b0};
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign bus.dout  = dout_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_q5_my_serial_left_shifter.sv
// Directed bench for the serial left shifter with hand-computed expected results.
module tb_q5_my_serial_left_shifter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  q5_my_serial_left_shifter_if #(.WIDTH(4)) bus ();

  q5_my_serial_left_shifter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request for exactly one accept edge.
  task automatic start_op(input logic [3:0] d, input logic [3:0] a);
    bus.din   = d;
    bus.amt   = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges from the accept edge until done shows, counting busy cycles on the way.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [3:0] exp_dout, input logic exp_err);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_lat);
    check({tag, "_dout"}, bus.dout, exp_dout);
    check({tag, "_err"}, bus.err, exp_err);
  endtask

  task automatic finish_op(input string tag);
    tick();
    check({tag, "_done_clr"}, bus.done, 1'b0);
    check({tag, "_ready"}, bus.ready, 1'b1);
  endtask

  initial begin
    int seen;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.din   = 4'b1011;
    bus.amt   = 4'b0100;

    // Reset with start held high: nothing may be accepted.
    tick();
    tick();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy",  bus.busy,  1'b0);
    check("rst_done",  bus.done,  1'b0);
    check("rst_dout",  bus.dout,  4'b0000);
    check("rst_err",   bus.err,   1'b0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("rst_not_accepted", bus.ready, 1'b1);

    start_op(4'b1011, 4'b0100);
    check("shl2_busy_e0", bus.busy, 1'b1);
    wait_done("shl2", 3, 4'b1100, 1'b0);
    finish_op("shl2");

    start_op(4'b1111, 4'b0110);
    wait_done("ill_0110", 0, 4'b0000, 1'b1);
    finish_op("ill_0110");

    start_op(4'b1111, 4'b0000);
    wait_done("ill_0000", 0, 4'b0000, 1'b1);
    finish_op("ill_0000");

    start_op(4'b1011, 4'b0001);
    wait_done("shl0", 1, 4'b1011, 1'b0);
    finish_op("shl0");

    start_op(4'b1111, 4'b1000);
    wait_done("shl3", 4, 4'b1000, 1'b0);
    finish_op("shl3");

    // Back-to-back: start stays high, second request waits for ready.
    bus.din   = 4'b0011;
    bus.amt   = 4'b0010;
    bus.start = 1'b1;
    tick();
    bus.din   = 4'b0001;
    bus.amt   = 4'b1000;
    wait_done("b2b_first", 2, 4'b0110, 1'b0);
    tick();
    check("b2b_ready_gap", bus.ready, 1'b1);
    tick();
    bus.start = 1'b0;
    wait_done("b2b_second", 4, 4'b1000, 1'b0);
    finish_op("b2b_second");
    tick();
    check("b2b_no_third", bus.busy, 1'b0);

    // Reset in the middle of a shift by 3.
    start_op(4'b1111, 4'b1000);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_ready", bus.ready, 1'b1);
    check("midrst_dout",  bus.dout,  4'b0000);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) seen++;
      tick();
    end
    check("midrst_no_done", seen, 0);
    check("midrst_dout_hold", bus.dout, 4'b0000);

    start_op(4'b0101, 4'b0010);
    wait_done("post_rst", 2, 4'b1010, 1'b0);
    finish_op("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
